pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard controller for the RV32I pipeline: forwarding selection, load-use stall and branch flush.
//  Generalises the 2-stage forwarding unit to NSTG post-EX stages and multi-cycle loads.
//  Adds a stall/flush sequencer FSM and drives the pipeline-register stall/flush enables.
//  Sits beside the pipeline top; it observes the ID, EX and later-stage register addresses.
// PARAMETERS
//  RADDR_W      5  register address width
//  NSTG         2  forwardable stages after EX (1 = MA, 2 = WB, ...)
//  LOAD_LAT     1  load-use stall length in cycles (>=1)
//  FLUSH_DEPTH  2  cycles flush is held after a taken branch/jump (>=1)
//  LOAD_FWD_MIN 2  lowest stage index whose load result is forwardable
//  SEL_W (localparam) = $clog2(NSTG+1)
// PORTS
//  clk         in   1               clock, rising edge
//  reset_n     in   1               async active-low reset
//  rs1_id      in   RADDR_W         ID source 1; use_rs1_id in 1 = source 1 is read
//  rs2_id      in   RADDR_W         ID source 2; use_rs2_id in 1 = source 2 is read
//  rs1_ex      in   RADDR_W         EX source 1
//  rs2_ex      in   RADDR_W         EX source 2
//  rd_ex       in   RADDR_W         EX destination
//  wen_ex      in   1               EX writes rd
//  load_ex     in   1               EX instruction is a load
//  rd_stg      in   NSTG*RADDR_W    destinations; slice k-1 = stage k
//  wen_stg     in   NSTG            write enables per stage
//  load_stg    in   NSTG            load flags per stage
//  pc_sel      in   1               taken branch/jump resolved this cycle
//  fwd_sel_a   out  SEL_W           0 = regfile, k = stage k
//  fwd_sel_b   out  SEL_W           as fwd_sel_a, for rs2
//  stall_pc    out  1               hold PC
//  stall_ifid  out  1               hold IF/ID register
//  flush_ifid  out  1               clear IF/ID register
//  flush_idex  out  1               insert bubble into ID/EX
//  stall_cnt   out  32              stall cycles (perf option)
//  flush_cnt   out  32              flush events (perf option)
// BEHAVIOUR
//  - Reset (reset_n low, async): FSM=RUN, counter=0, every output 0 (fwd_sel included) while low.
//  - Forwarding is combinational, zero latency, and evaluated per operand.
//    Candidate stage k requires: wen_stg[k-1], rd!=0, rd==rs_ex, and !(load_stg[k-1] && k<LOAD_FWD_MIN).
//    The lowest k wins (youngest). No candidate selects 0. x0 is never forwarded.
//  - Hazard H = load_ex & wen_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
//  - FSM states RUN, STALL, FLUSH, with a down-counter cnt.
//    RUN: pc_sel -> flush this cycle. If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-1.
//    RUN: else H -> stall this cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
//    STALL: stall asserted. cnt-- each cycle; on the cycle cnt==1, go to RUN.
//    STALL: pc_sel preempts the stall: flush this cycle and enter FLUSH (same rule as RUN).
//    FLUSH: flush asserted. cnt-- each cycle; on the cycle cnt==1, go to RUN.
//    FLUSH: pc_sel restarts cnt=FLUSH_DEPTH-1. H is ignored while in FLUSH.
//  - Stall cycle: stall_pc=stall_ifid=flush_idex=1, flush_ifid=0.
//  - Flush cycle: flush_ifid=flush_idex=1, stall_pc=stall_ifid=0.
//  - Result: stall spans exactly LOAD_LAT cycles and flush exactly FLUSH_DEPTH cycles.
//  - pc_sel and H in the same cycle: flush wins and no stall is recorded.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//    stall_cnt +1 per stall cycle; flush_cnt +1 per pc_sel accepted.
//    Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
//  HAZARD_PERF_EN undefined: stall_cnt and flush_cnt tied to 0, and no counter flops exist.
// STRUCTURE
//  pipe_hazard_pkg holds:
//    hz_state_t {HZ_RUN, HZ_STALL, HZ_FLUSH}
//    FWD_REGFILE=0
//    an SEL_W helper function
//  Sub-module fwd_select: priority encoder per operand, instantiated twice (rs1_ex, rs2_ex).
//  The top holds the FSM, the counter and the optional perf counters.
// TESTING
//  1 rs1_ex=5; stg1 rd=5 wen; stg2 rd=5 wen -> fwd_sel_a=1. Drop stg1 wen -> 2. rs1_ex=0 -> 0.
//  2 load_ex=1, rd_ex=7, rs2_id=7, use_rs2_id=1, LOAD_LAT=1:
//    stall_pc/stall_ifid/flush_idex high exactly 1 cycle, then 0.
//  3 LOAD_LAT=3, same hazard -> stall held 3 cycles.
//    Same stimulus with pc_sel in the 2nd stall cycle -> stall drops and flush runs 2 cycles.
//  4 pc_sel pulse, FLUSH_DEPTH=2 -> flush_ifid/flush_idex high 2 cycles.
//    pc_sel again in the 2nd flush cycle -> flush extended to 3 cycles total.
//  5 stg1 load rd=9, rs2_ex=9, LOAD_FWD_MIN=2 -> fwd_sel_b=0 (not 1).
//    Move the load to stg2 -> fwd_sel_b=2.
//  6 reset_n low mid-STALL -> all outputs 0 immediately; RUN after release.
//    With HAZARD_PERF_EN: counters read 0 after reset, 3 after a LOAD_LAT=3 stall.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg: shared types and helpers for the pipeline hazard controller
package pipe_hazard_pkg;
  typedef enum logic [1:0] {HZ_RUN = 2'd0, HZ_STALL = 2'd1, HZ_FLUSH = 2'd2} hz_state_t;
  localparam int FWD_REGFILE = 0;
  function automatic int sel_width(input int nstg);
    return $clog2(nstg + 1);
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// fwd_select: per-operand forwarding priority encoder over the post-EX stages
// Ports: rs (EX source), rd_stg/wen_stg/load_stg (stage k in slice k-1), sel (0 = regfile, k = stage k)
module fwd_select
  import pipe_hazard_pkg::*;
#(
  parameter int RADDR_W = 5,
  parameter int NSTG = 2,
  parameter int LOAD_FWD_MIN = 2,
  parameter int SEL_W = 2
) (
  input  logic [RADDR_W-1:0]      rs,
  input  logic [NSTG*RADDR_W-1:0] rd_stg,
  input  logic [NSTG-1:0]         wen_stg,
  input  logic [NSTG-1:0]         load_stg,
  output logic [SEL_W-1:0]        sel
);
  // scan oldest to youngest so the lowest matching stage overwrites the rest
  always_comb begin
    sel = SEL_W'(FWD_REGFILE);
    for (int k = NSTG; k >= 1; k--)
      if (wen_stg[k-1] && rd_stg[(k-1)*RADDR_W +: RADDR_W] != '0 &&
          rd_stg[(k-1)*RADDR_W +: RADDR_W] == rs && !(load_stg[k-1] && k < LOAD_FWD_MIN))
        sel = SEL_W'(k);
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RV32I forwarding select, load-use stall and branch flush sequencer
// Inputs: clk, reset_n (async, active low), ID sources rs1_id/rs2_id with use flags, EX rs1_ex/rs2_ex/rd_ex,
//   wen_ex, load_ex, per-stage rd_stg/wen_stg/load_stg, pc_sel (taken branch/jump).
// Outputs: fwd_sel_a/fwd_sel_b, stall_pc, stall_ifid, flush_ifid, flush_idex, stall_cnt, flush_cnt.
// Option: define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int RADDR_W = 5,
  parameter int NSTG = 2,
  parameter int LOAD_LAT = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_FWD_MIN = 2,
  localparam int SEL_W = sel_width(NSTG)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [RADDR_W-1:0]      rs1_id,
  input  logic                    use_rs1_id,
  input  logic [RADDR_W-1:0]      rs2_id,
  input  logic                    use_rs2_id,
  input  logic [RADDR_W-1:0]      rs1_ex,
  input  logic [RADDR_W-1:0]      rs2_ex,
  input  logic [RADDR_W-1:0]      rd_ex,
  input  logic                    wen_ex,
  input  logic                    load_ex,
  input  logic [NSTG*RADDR_W-1:0] rd_stg,
  input  logic [NSTG-1:0]         wen_stg,
  input  logic [NSTG-1:0]         load_stg,
  input  logic                    pc_sel,
  output logic [SEL_W-1:0]        fwd_sel_a,
  output logic [SEL_W-1:0]        fwd_sel_b,
  output logic                    stall_pc,
  output logic                    stall_ifid,
  output logic                    flush_ifid,
  output logic                    flush_idex,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
);
  hz_state_t state, nstate;
  logic [31:0] cnt, ncnt;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic hz, do_flush, do_stall;
  fwd_select #(.RADDR_W(RADDR_W), .NSTG(NSTG), .LOAD_FWD_MIN(LOAD_FWD_MIN), .SEL_W(SEL_W)) u_fwd_a (
    .rs(rs1_ex), .rd_stg(rd_stg), .wen_stg(wen_stg), .load_stg(load_stg), .sel(sel_a)
  );
  fwd_select #(.RADDR_W(RADDR_W), .NSTG(NSTG), .LOAD_FWD_MIN(LOAD_FWD_MIN), .SEL_W(SEL_W)) u_fwd_b (
    .rs(rs2_ex), .rd_stg(rd_stg), .wen_stg(wen_stg), .load_stg(load_stg), .sel(sel_b)
  );
  assign hz = load_ex & wen_ex & (rd_ex != '0) &
              ((use_rs1_id & (rs1_id == rd_ex)) | (use_rs2_id & (rs2_id == rd_ex)));
  // a taken branch outranks everything; a pending load-use hazard is dropped behind a flush
  assign do_flush = pc_sel | (state == HZ_FLUSH);
  assign do_stall = !do_flush && (state == HZ_STALL || hz);
  always_comb begin
    nstate = state;
    ncnt = cnt;
    if (pc_sel) begin
      nstate = FLUSH_DEPTH > 1 ? HZ_FLUSH : HZ_RUN;
      ncnt = 32'(FLUSH_DEPTH - 1);
    end else if (state != HZ_RUN) begin
      nstate = cnt == 1 ? HZ_RUN : state;
      ncnt = cnt - 1;
    end else if (hz) begin
      nstate = LOAD_LAT > 1 ? HZ_STALL : HZ_RUN;
      ncnt = 32'(LOAD_LAT - 1);
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= HZ_RUN;
      cnt <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
    end
  // combinational outputs are forced low for as long as reset is held
  assign fwd_sel_a = reset_n ? sel_a : '0;
  assign fwd_sel_b = reset_n ? sel_b : '0;
  assign stall_pc = reset_n & do_stall;
  assign stall_ifid = reset_n & do_stall;
  assign flush_ifid = reset_n & do_flush;
  assign flush_idex = reset_n & (do_flush | do_stall);
`ifdef HAZARD_PERF_EN
  logic [31:0] s_cnt, f_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s_cnt <= '0;
      f_cnt <= '0;
    end else begin
      if (do_stall && ~&s_cnt) s_cnt <= s_cnt + 1;
      if (pc_sel && ~&f_cnt) f_cnt <= f_cnt + 1;
    end
  assign stall_cnt = s_cnt;
  assign flush_cnt = f_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table, directed and random checks of pipe_hazard_ctrl against a cycle-window model
module tb_pipe_hazard_ctrl;
  localparam int FD = 2;
  logic clk = 0, reset_n = 0;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex;
  logic use_rs1_id, use_rs2_id, wen_ex, load_ex, pc_sel;
  logic [9:0] rd_stg;
  logic [1:0] wen_stg, load_stg;
  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic stall_pc [2];
  logic stall_ifid [2];
  logic flush_ifid [2];
  logic flush_idex [2];
  logic [31:0] scnt [2];
  logic [31:0] fcnt [2];
  int total = 0, passed = 0, cyc = 0;
  int fe [2], se [2], sc [2], fc [2];
  int ll [2] = '{1, 3};
  typedef struct {
    logic [4:0] rs1, rs2, rd1, rd2;
    logic [1:0] wen, ld;
    int ea, eb;
  } fv_t;
  fv_t tab [8];
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.LOAD_LAT(1), .FLUSH_DEPTH(FD)) d1 (
    .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .use_rs1_id(use_rs1_id), .rs2_id(rs2_id),
    .use_rs2_id(use_rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .wen_ex(wen_ex),
    .load_ex(load_ex), .rd_stg(rd_stg), .wen_stg(wen_stg), .load_stg(load_stg), .pc_sel(pc_sel),
    .fwd_sel_a(fa[0]), .fwd_sel_b(fb[0]), .stall_pc(stall_pc[0]), .stall_ifid(stall_ifid[0]),
    .flush_ifid(flush_ifid[0]), .flush_idex(flush_idex[0]), .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
  );
  pipe_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_DEPTH(FD)) d3 (
    .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .use_rs1_id(use_rs1_id), .rs2_id(rs2_id),
    .use_rs2_id(use_rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .wen_ex(wen_ex),
    .load_ex(load_ex), .rd_stg(rd_stg), .wen_stg(wen_stg), .load_stg(load_stg), .pc_sel(pc_sel),
    .fwd_sel_a(fa[1]), .fwd_sel_b(fb[1]), .stall_pc(stall_pc[1]), .stall_ifid(stall_ifid[1]),
    .flush_ifid(flush_ifid[1]), .flush_idex(flush_idex[1]), .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
  endtask
  function automatic logic [3:0] pk(input int i);
    return {stall_pc[i], stall_ifid[i], flush_ifid[i], flush_idex[i]};
  endfunction
  function automatic bit hz_m();
    return load_ex && wen_ex && rd_ex != 0 &&
           ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
  endfunction
  function automatic int fwd_m(input logic [4:0] rs);
    logic [4:0] r;
    for (int k = 1; k <= 2; k++) begin
      r = rd_stg[(k-1)*5 +: 5];
      if (rs != 0 && wen_stg[k-1] && r == rs && !(load_stg[k-1] && k < 2)) return k;
    end
    return 0;
  endfunction
  function automatic void calc(input int i, output bit fl, output bit st);
    fl = pc_sel || cyc < fe[i];
    st = !fl && (cyc < se[i] || hz_m());
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      fe[i] = 0; se[i] = 0; sc[i] = 0; fc[i] = 0;
    end
  endtask
  task automatic model_check();
    bit fl, st;
    int es, ef;
    for (int i = 0; i < 2; i++) begin
      calc(i, fl, st);
      check($sformatf("ctl%0d", i), 32'(pk(i)), fl ? 32'h3 : st ? 32'hd : 32'h0);
      check($sformatf("fwd_a%0d", i), 32'(fa[i]), 32'(fwd_m(rs1_ex)));
      check($sformatf("fwd_b%0d", i), 32'(fb[i]), 32'(fwd_m(rs2_ex)));
`ifdef HAZARD_PERF_EN
      es = sc[i]; ef = fc[i];
`else
      es = 0; ef = 0;
`endif
      check($sformatf("stall_cnt%0d", i), scnt[i], 32'(es));
      check($sformatf("flush_cnt%0d", i), fcnt[i], 32'(ef));
    end
  endtask
  task automatic model_adv();
    bit fl, st;
    for (int i = 0; i < 2; i++) begin
      calc(i, fl, st);
      if (pc_sel) begin
        fe[i] = cyc + FD; se[i] = 0; fc[i]++;
      end else if (!fl && cyc >= se[i] && hz_m()) se[i] = cyc + ll[i];
      if (st) sc[i]++;
    end
    cyc++;
  endtask
  task automatic step();
    #2;
    model_check();
    model_adv();
    @(posedge clk);
    #1;
  endtask
  task automatic stepx(input logic [3:0] e1, input logic [3:0] e3);
    #2;
    check("seq_ll1", 32'(pk(0)), 32'(e1));
    check("seq_ll3", 32'(pk(1)), 32'(e3));
    model_check();
    model_adv();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex} = '0;
    {use_rs1_id, use_rs2_id, wen_ex, load_ex, pc_sel} = '0;
    rd_stg = '0; wen_stg = '0; load_stg = '0;
  endtask
  task automatic set_hz(input bit on);
    load_ex = on; wen_ex = on; rd_ex = on ? 5'd7 : 5'd0;
    rs2_id = on ? 5'd7 : 5'd0; use_rs2_id = on;
  endtask
  initial begin
    clr();
    model_reset();
    rs1_ex = 5; rd_stg = {5'd5, 5'd5}; wen_stg = 2'b11;
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_ctl", 32'(pk(i)), 0);
      check("rst_fwd_a", 32'(fa[i]), 0);
      check("rst_cnt", scnt[i] | fcnt[i], 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1;
    clr();
    tab[0] = '{5'd5, 5'd0, 5'd5, 5'd5, 2'b11, 2'b00, 1, 0};
    tab[1] = '{5'd5, 5'd0, 5'd5, 5'd5, 2'b10, 2'b00, 2, 0};
    tab[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 2'b00, 0, 0};
    tab[3] = '{5'd0, 5'd9, 5'd9, 5'd0, 2'b01, 2'b01, 0, 0};
    tab[4] = '{5'd0, 5'd9, 5'd0, 5'd9, 2'b10, 2'b10, 0, 2};
    tab[5] = '{5'd3, 5'd3, 5'd3, 5'd3, 2'b11, 2'b01, 2, 2};
    tab[6] = '{5'd4, 5'd6, 5'd6, 5'd4, 2'b11, 2'b10, 2, 1};
    tab[7] = '{5'd7, 5'd0, 5'd8, 5'd9, 2'b11, 2'b00, 0, 0};
    foreach (tab[n]) begin
      rs1_ex = tab[n].rs1; rs2_ex = tab[n].rs2; rd_stg = {tab[n].rd2, tab[n].rd1};
      wen_stg = tab[n].wen; load_stg = tab[n].ld;
      #1;
      check($sformatf("tab%0d_a", n), 32'(fa[0]), 32'(tab[n].ea));
      check($sformatf("tab%0d_b", n), 32'(fb[0]), 32'(tab[n].eb));
      step();
    end
    clr();
    set_hz(1); stepx(4'hd, 4'hd);
    set_hz(0); stepx(4'h0, 4'hd);
    stepx(4'h0, 4'hd);
    stepx(4'h0, 4'h0);
    set_hz(1); stepx(4'hd, 4'hd);
    set_hz(0); pc_sel = 1; stepx(4'h3, 4'h3);
    pc_sel = 0; stepx(4'h3, 4'h3);
    stepx(4'h0, 4'h0);
    pc_sel = 1; stepx(4'h3, 4'h3);
    pc_sel = 0; stepx(4'h3, 4'h3);
    stepx(4'h0, 4'h0);
    pc_sel = 1; stepx(4'h3, 4'h3);
    pc_sel = 1; stepx(4'h3, 4'h3);
    pc_sel = 0; stepx(4'h3, 4'h3);
    stepx(4'h0, 4'h0);
    set_hz(1); pc_sel = 1; stepx(4'h3, 4'h3);
    set_hz(0); pc_sel = 0; stepx(4'h3, 4'h3);
    stepx(4'h0, 4'h0);
    set_hz(1); stepx(4'hd, 4'hd);
    set_hz(0);
    rs1_ex = 5; rd_stg = {5'd5, 5'd5}; wen_stg = 2'b11;
    reset_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_ctl", 32'(pk(i)), 0);
      check("midrst_fwd", 32'(fa[i]), 0);
      check("midrst_cnt", scnt[i] | fcnt[i], 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    clr();
    stepx(4'h0, 4'h0);
    set_hz(1); stepx(4'hd, 4'hd);
    set_hz(0); stepx(4'h0, 4'hd);
    stepx(4'h0, 4'hd);
    stepx(4'h0, 4'h0);
`ifdef HAZARD_PERF_EN
    check("perf_stall3", scnt[1], 3);
    check("perf_stall1", scnt[0], 1);
`else
    check("perf_stall3", scnt[1], 0);
    check("perf_stall1", scnt[0], 0);
`endif
    for (int n = 0; n < 500; n++) begin
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
      use_rs1_id = 1'($urandom); use_rs2_id = 1'($urandom);
      rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3));
      wen_ex = $urandom_range(0, 3) != 0; load_ex = 1'($urandom);
      pc_sel = $urandom_range(0, 9) == 0;
      rd_stg = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      wen_stg = 2'($urandom); load_stg = 2'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
